muldiv_control: RTL

Multi-cycle multiply/divide sequencer beside the execution stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execution-stage control word, runs an iterative shift-add multiply or restoring divide over NB_REG cycles, and owns the architectural HI/LO registers. It raises a stall to the pipeline whenever an instruction needs the unit or HI/LO while an operation is still in flight.

---
 rtl/muldiv_control_pkg.sv | 20 ++
 rtl/muldiv_core.sv | 45 ++++
 rtl/muldiv_control.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_control_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM states, defaults.
// Divide support is selected with the MULDIV_DIV_EN macro.
package muldiv_control_pkg;

    localparam int MULDIV_NB_COUNT = 6;

    localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_MTHI  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_core.sv
// One combinational iteration: shift-add multiply step and, with MULDIV_DIV_EN,
// a restoring-divide step on the shared {upper, lower} accumulator.
module muldiv_core
    import muldiv_control_pkg::*;
#(
    parameter int NB_REG = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic                  i_is_div,
    input  logic [NB_REG-1:0]     i_divisor,
`endif
    input  logic [2*NB_REG-1:0]   i_acc,
    input  logic [NB_REG-1:0]     i_mcand,
    output logic [2*NB_REG-1:0]   o_acc
);

    logic [NB_REG:0]     mul_sum;
    logic [2*NB_REG-1:0] mul_next;

    // Multiplier sits in the low half; its LSB gates the add, carry shifts into the top.
    always_comb begin
        mul_sum  = {1'b0, i_acc[2*NB_REG-1:NB_REG]} + (i_acc[0] ? {1'b0, i_mcand} : '0);
        mul_next = {mul_sum, i_acc[NB_REG-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [NB_REG:0]     div_upper;
    logic                div_ge;
    logic [NB_REG-1:0]   div_rem;
    logic [2*NB_REG-1:0] div_next;

    // Remainder in the high half, dividend bits shift out of the low half as quotient bits shift in.
    always_comb begin
        div_upper = i_acc[2*NB_REG-1:NB_REG-1];
        div_ge    = div_upper >= {1'b0, i_divisor};
        div_rem   = div_ge ? (div_upper[NB_REG-1:0] - i_divisor) : div_upper[NB_REG-1:0];
        div_next  = {div_rem, i_acc[NB_REG-2:0], div_ge};
    end

    assign o_acc = i_is_div ? div_next : mul_next;
`else
    assign o_acc = mul_next;
`endif

endmodule

// File: rtl/muldiv_control.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall generation.
// Define MULDIV_DIV_EN to build the divide path; otherwise DIV/DIVU are no-ops.
module muldiv_control
    import muldiv_control_pkg::*;
#(
    parameter int NB_REG   = 32,
    parameter int NB_OP    = 3,
    parameter int NB_COUNT = MULDIV_NB_COUNT
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_start,
    input  logic [NB_OP-1:0]  i_op,
    input  logic [NB_REG-1:0] i_a,
    input  logic [NB_REG-1:0] i_b,
    input  logic              i_read_hilo,
    output logic [NB_REG-1:0] o_hi,
    output logic [NB_REG-1:0] o_lo,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done
);

    muldiv_state_e       state_q, state_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic [2*NB_REG-1:0] acc_q, acc_d, acc_step;
    logic [NB_REG-1:0]   mcand_q, mcand_d;
    logic                neg_lo_q, neg_lo_d;
    logic [NB_REG-1:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic [NB_REG-1:0]   divisor_q, divisor_d;
    logic                is_div_q, is_div_d;
    logic                neg_hi_q, neg_hi_d;
    logic                op_div, op_divu;
`endif

    logic                op_mult, op_multu, op_mthi, op_mtlo;
    logic                op_long, op_signed;
    logic                a_neg, b_neg;
    logic [NB_REG-1:0]   a_mag, b_mag;
    logic                busy, stall, accept;
    logic [2*NB_REG-1:0] fixed_prod;

    muldiv_core #(.NB_REG(NB_REG)) u_core (
`ifdef MULDIV_DIV_EN
        .i_is_div  (is_div_q),
        .i_divisor (divisor_q),
`endif
        .i_acc     (acc_q),
        .i_mcand   (mcand_q),
        .o_acc     (acc_step)
    );

    always_comb begin
        op_mult   = i_op == NB_OP'(MULDIV_OP_MULT);
        op_multu  = i_op == NB_OP'(MULDIV_OP_MULTU);
        op_mthi   = i_op == NB_OP'(MULDIV_OP_MTHI);
        op_mtlo   = i_op == NB_OP'(MULDIV_OP_MTLO);
`ifdef MULDIV_DIV_EN
        op_div    = i_op == NB_OP'(MULDIV_OP_DIV);
        op_divu   = i_op == NB_OP'(MULDIV_OP_DIVU);
        op_long   = op_mult | op_multu | op_div | op_divu;
        op_signed = op_mult | op_div;
`else
        op_long   = op_mult | op_multu;
        op_signed = op_mult;
`endif
        a_neg     = op_signed & i_a[NB_REG-1];
        b_neg     = op_signed & i_b[NB_REG-1];
        a_mag     = a_neg ? ('0 - i_a) : i_a;
        b_mag     = b_neg ? ('0 - i_b) : i_b;

        busy       = state_q != ST_IDLE;
        stall      = busy & i_valid & (i_read_hilo | i_start);
        accept     = (state_q == ST_IDLE) & i_valid & i_start & ~stall;
        fixed_prod = neg_lo_q ? ('0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_lo_d  = neg_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
        divisor_d = divisor_q;
        is_div_d  = is_div_q;
        neg_hi_d  = neg_hi_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_long) begin
                        state_d  = ST_CALC;
                        count_d  = NB_COUNT'(NB_REG - 1);
                        mcand_d  = a_mag;
                        acc_d    = {{NB_REG{1'b0}}, b_mag};
                        neg_lo_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        is_div_d  = op_div | op_divu;
                        divisor_d = b_mag;
                        neg_hi_d  = a_neg;
                        if (op_div | op_divu) begin
                            acc_d    = {{NB_REG{1'b0}}, a_mag};
                            // A zero divisor leaves an all-ones quotient and the dividend as remainder.
                            neg_lo_d = (a_neg ^ b_neg) & (i_b != '0);
                        end
`endif
                    end
                    if (op_mthi) hi_d = i_a;
                    if (op_mtlo) lo_d = i_a;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                if (count_q == '0) state_d = ST_FIX;
                else               count_d = count_q - NB_COUNT'(1);
            end
            ST_FIX: begin
                state_d = ST_IDLE;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = neg_lo_q ? ('0 - acc_q[NB_REG-1:0]) : acc_q[NB_REG-1:0];
                    hi_d = neg_hi_q ? ('0 - acc_q[2*NB_REG-1:NB_REG]) : acc_q[2*NB_REG-1:NB_REG];
                end else begin
                    {hi_d, lo_d} = fixed_prod;
                end
`else
                {hi_d, lo_d} = fixed_prod;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand/accumulator registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge i_clock) begin
        acc_q     <= acc_d;
        mcand_q   <= mcand_d;
        neg_lo_q  <= neg_lo_d;
`ifdef MULDIV_DIV_EN
        divisor_q <= divisor_d;
        is_div_q  <= is_div_d;
        neg_hi_q  <= neg_hi_d;
`endif
    end

    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_busy  = busy;
    assign o_stall = stall;
    assign o_done  = state_q == ST_FIX;

endmodule
